// File: rtl/data_word_packer_pkg.sv
// Shared definitions for the data word packer.
// Defaults, width helpers, and FSM states are also used for the width of the consumer's data port.
package data_word_pkg;

  localparam int DEF_LANES  = 2;
  localparam int DEF_FLAG_W = 1;
  localparam int DEF_VAL_W  = 3;

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

  function automatic int field_w(input int flag_w = DEF_FLAG_W, input int val_w = DEF_VAL_W);
    return flag_w + val_w;
  endfunction

  function automatic int data_w(input int lanes  = DEF_LANES,
                                input int flag_w = DEF_FLAG_W,
                                input int val_w  = DEF_VAL_W);
    return lanes * field_w(flag_w, val_w);
  endfunction

endpackage

// File: rtl/data_word_packer_if.sv
// Field-in / word-out handshake bundle.
// The master modport is the packer itself; slave is the field source plus the word consumer.
interface data_word_packer_if
  import data_word_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int VAL_W  = DEF_VAL_W
);

  localparam int DATA_W = data_w(LANES, FLAG_W, VAL_W);
  localparam int CNT_W  = $clog2(LANES + 1);

  logic [FLAG_W-1:0] in_flag;
  logic [VAL_W-1:0]  in_value;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  data_count;
  logic              data_valid;
  logic              data_ready;

  modport master (
    input  in_flag, in_value, in_last, in_valid, data_ready,
    output in_ready, data, data_count, data_valid
  );

  modport slave (
    output in_flag, in_value, in_last, in_valid, data_ready,
    input  in_ready, data, data_count, data_valid
  );

endinterface

// File: rtl/data_word_packer_lane_insert.sv
// Combinational lane write-enable decoder.
// When enabled, this block writes one field into the selected lane of a word and passes all other lanes through unchanged.
module field_lane_insert
  import data_word_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int FIELD_W = field_w(),
  parameter int LANE_W  = $clog2(LANES + 1)
) (
  input  logic [LANES*FIELD_W-1:0] word_i,
  input  logic [LANE_W-1:0]        lane_i,
  input  logic [FIELD_W-1:0]       field_i,
  input  logic                     en_i,
  output logic [LANES*FIELD_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (en_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_i == LANE_W'(k)) begin
          word_o[k*FIELD_W +: FIELD_W] = field_i;
        end
      end
    end
  end

endmodule

// File: rtl/data_word_packer.sv
// Packs LANES {flag, value} fields into one word with lane 0 in the LSBs.
// The finished word is held on a valid/ready output until it is consumed.
module data_word_packer
  import data_word_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int VAL_W  = DEF_VAL_W
) (
  input logic             clk,
  input logic             rst,
  data_word_packer_if.master bus
);

  localparam int FIELD_W = field_w(FLAG_W, VAL_W);
  localparam int DATA_W  = data_w(LANES, FLAG_W, VAL_W);
  localparam int CNT_W   = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] ins_word;
  logic              in_ready;
  logic              accept;
  logic              closes;
  logic              out_hs;

  assign in_ready = ~rst & ((state_q == FILL) | bus.data_ready);
  assign accept   = bus.in_valid & in_ready;
  assign out_hs   = valid_q & bus.data_ready;
  assign closes   = accept & ((cnt_q == LAST_LANE) | bus.in_last);

  // cnt_q and asm_q are zero in HOLD, so this produces lane 0 of a fresh word there
  field_lane_insert #(
    .LANES  (LANES),
    .FIELD_W(FIELD_W),
    .LANE_W (CNT_W)
  ) u_lane_insert (
    .word_i (asm_q),
    .lane_i (cnt_q),
    .field_i({bus.in_flag, bus.in_value}),
    .en_i   (accept),
    .word_o (ins_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    case (state_q)
      FILL: begin
        if (closes) begin
          data_d  = ins_word;
          count_d = cnt_q + CNT_W'(1);
          valid_d = 1'b1;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = HOLD;
        end else if (accept) begin
          asm_d = ins_word;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_hs) begin
          // A field accepted during the handshake opens the next word immediately
          if (closes) begin
            data_d  = ins_word;
            count_d = cnt_q + CNT_W'(1);
          end else begin
            valid_d = 1'b0;
            state_d = FILL;
            if (accept) begin
              asm_d = ins_word;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.data       = data_q;
  assign bus.data_count = count_q;
  assign bus.data_valid = valid_q;

endmodule

// File: tb/tb_data_word_packer.sv
// Bench for data_word_packer: a two-lane and a one-lane instance are driven by the same field stream
// and compared every cycle against a word-level reference model.
module tb_data_word_packer;
  import data_word_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_word_packer_if #(.LANES(2), .FLAG_W(1), .VAL_W(3)) bus2();
  data_word_packer_if #(.LANES(1), .FLAG_W(1), .VAL_W(3)) bus1();

  data_word_packer #(.LANES(2), .FLAG_W(1), .VAL_W(3)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  data_word_packer #(.LANES(1), .FLAG_W(1), .VAL_W(3)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Model of each instance (index 0: two lanes, 1: one lane), kept as fields collected and words awaiting pickup
  int         lanesOf   [2];
  logic [7:0] partWord  [2];
  int         partCnt   [2];
  logic [7:0] expWord   [2];
  int         expCnt    [2];
  bit         pending   [2];
  bit         freshReset[2];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      partWord[d]   = 8'h00;
      partCnt[d]    = 0;
      expWord[d]    = 8'h00;
      expCnt[d]     = 0;
      pending[d]    = 1'b0;
      freshReset[d] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, check both instances, advance the model across the next rising edge
  task automatic applyStimulus(input bit v, input bit f, input logic [2:0] val,
                               input bit l, input bit r, input bit rs);
    bus2.in_valid = v;   bus1.in_valid = v;
    bus2.in_flag  = f;   bus1.in_flag  = f;
    bus2.in_value = val; bus1.in_value = val;
    bus2.in_last  = l;   bus1.in_last  = l;
    bus2.data_ready = r; bus1.data_ready = r;
    rst = rs;
    #1;
    for (int d = 0; d < 2; d++) begin
      logic       actReady;
      logic       actValid;
      logic [7:0] actData;
      logic [1:0] actCnt;
      bit         expReady;
      string      pfx;
      pfx = $sformatf("lanes%0d", lanesOf[d]);
      if (d == 0) begin
        actReady = bus2.in_ready;
        actValid = bus2.data_valid;
        actData  = bus2.data;
        actCnt   = bus2.data_count;
      end else begin
        actReady = bus1.in_ready;
        actValid = bus1.data_valid;
        actData  = {4'h0, bus1.data};
        actCnt   = {1'b0, bus1.data_count};
      end
      expReady = !rs && (!pending[d] || r);
      checkOutput({pfx, "_in_ready"}, 32'(actReady), 32'(expReady));
      checkOutput({pfx, "_data_valid"}, 32'(actValid), 32'(pending[d]));
      if (pending[d]) begin
        checkOutput({pfx, "_data"}, 32'(actData), 32'(expWord[d]));
        checkOutput({pfx, "_data_count"}, 32'(actCnt), 32'(expCnt[d]));
      end else if (freshReset[d]) begin
        checkOutput({pfx, "_data_after_reset"}, 32'(actData), 32'd0);
        checkOutput({pfx, "_count_after_reset"}, 32'(actCnt), 32'd0);
      end
      if (!rs) begin
        if (pending[d] && r) pending[d] = 1'b0;
        if (v && expReady) begin
          partWord[d] = partWord[d] | (8'({f, val}) << (4 * partCnt[d]));
          partCnt[d]++;
          if (partCnt[d] == lanesOf[d] || l) begin
            expWord[d]    = partWord[d];
            expCnt[d]     = partCnt[d];
            pending[d]    = 1'b1;
            freshReset[d] = 1'b0;
            partWord[d]   = 8'h00;
            partCnt[d]    = 0;
          end
        end
      end
    end
    if (rs) modelReset();
    @(negedge clk);
  endtask

  initial begin
    lanesOf[0] = 2;
    lanesOf[1] = 1;
    bus2.in_valid = 1'b0; bus1.in_valid = 1'b0;
    bus2.in_flag  = 1'b0; bus1.in_flag  = 1'b0;
    bus2.in_value = 3'd0; bus1.in_value = 3'd0;
    bus2.in_last  = 1'b0; bus1.in_last  = 1'b0;
    bus2.data_ready = 1'b0; bus1.data_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    modelReset();

    // Basic packing: (1,5) then (0,3)
    applyStimulus(1, 1, 3'd5, 0, 1, 0);
    applyStimulus(1, 0, 3'd3, 0, 1, 0);
    checkOutput("plan_basic_data", 32'(bus2.data), 32'h3D);
    checkOutput("plan_basic_count", 32'(bus2.data_count), 32'd2);
    applyStimulus(0, 0, 3'd0, 0, 1, 0);
    applyStimulus(0, 0, 3'd0, 0, 1, 0);

    // Early close with in_last
    applyStimulus(1, 1, 3'd7, 1, 1, 0);
    checkOutput("plan_early_data", 32'(bus2.data), 32'h0F);
    checkOutput("plan_early_count", 32'(bus2.data_count), 32'd1);
    applyStimulus(0, 0, 3'd0, 0, 1, 0);

    // Backpressure: word held while the next field waits
    applyStimulus(1, 1, 3'd5, 0, 1, 0);
    applyStimulus(1, 0, 3'd3, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 3'd1, 0, 0, 0);
    applyStimulus(1, 0, 3'd1, 0, 1, 0);
    applyStimulus(1, 1, 3'd2, 0, 1, 0);
    checkOutput("plan_bp_lane0", 32'(bus2.data[3:0]), 32'h1);
    applyStimulus(0, 0, 3'd0, 0, 1, 0);

    // Streaming: eight fields back to back
    for (int i = 0; i < 8; i++) applyStimulus(1, i[0], 3'(i), 0, 1, 0);
    applyStimulus(0, 0, 3'd0, 0, 1, 0);

    // Reset mid-word discards the partial word
    applyStimulus(1, 1, 3'd2, 0, 1, 0);
    applyStimulus(0, 0, 3'd0, 0, 1, 1);
    checkOutput("plan_reset_valid", 32'(bus2.data_valid), 32'd0);
    checkOutput("plan_reset_data", 32'(bus2.data), 32'd0);
    applyStimulus(1, 0, 3'd4, 0, 1, 0);
    applyStimulus(1, 0, 3'd6, 0, 1, 0);
    checkOutput("plan_reset_next_data", 32'(bus2.data), 32'h64);
    applyStimulus(0, 0, 3'd0, 0, 1, 0);

    // Randomised traffic with backpressure, early closes and occasional resets
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
